// File: rtl/sudoku_game_ctrl_if.sv
// Command and board-state bundle between the game front end and the 4x4 Sudoku sequencer.
// The master side issues load/button/digit pulses; the slave side returns the board and status.
interface sudoku_game_ctrl_if #(
  parameter int CELL_BITS = 4
);
  localparam int GRID_W = 16 * CELL_BITS;

  logic              load;
  logic [GRID_W-1:0] puzzle_in;
  logic              btn_up;
  logic              btn_down;
  logic              btn_left;
  logic              btn_right;
  logic              digit_valid;
  logic [2:0]        digit_in;

  logic [GRID_W-1:0] grid;
  logic [15:0]       fixed_mask;
  logic [1:0]        cursor_row;
  logic [1:0]        cursor_col;
  logic              error_flag;
  logic              win_flag;
  logic              busy;

  modport master (
    output load, puzzle_in, btn_up, btn_down, btn_left, btn_right, digit_valid, digit_in,
    input  grid, fixed_mask, cursor_row, cursor_col, error_flag, win_flag, busy
  );

  modport slave (
    input  load, puzzle_in, btn_up, btn_down, btn_left, btn_right, digit_valid, digit_in,
    output grid, fixed_mask, cursor_row, cursor_col, error_flag, win_flag, busy
  );
endinterface

// File: rtl/sudoku_game_ctrl.sv
// 4x4 Sudoku game sequencer: board/clue/cursor state, command handling and a
// one-unit-per-cycle conflict scan (4 rows, 4 columns, 4 boxes) after every accepted write.
module sudoku_game_ctrl #(
  parameter int N_UNITS   = 12,
  parameter int CELL_BITS = 4
) (
  input  logic              clk,
  input  logic              rst,
  sudoku_game_ctrl_if.slave bus
);
  localparam int GRID_W = 16 * CELL_BITS;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PLAY,
    ST_CHECK,
    ST_WIN
  } state_t;

  state_t            state_reg, state_next;
  logic [GRID_W-1:0] grid_reg, grid_next;
  logic [15:0]       fixed_reg, fixed_next;
  logic [1:0]        row_reg, row_next;
  logic [1:0]        col_reg, col_next;
  logic              error_reg, error_next;
  logic              win_reg, win_next;
  logic              busy_reg, busy_next;
  logic [3:0]        unit_reg, unit_next;
  logic              conflict_acc_reg, conflict_acc_next;

  logic [GRID_W-1:0]      load_grid;
  logic [15:0]            load_fixed;
  logic [15:0]            cell_nonzero;
  logic [4*CELL_BITS-1:0] unit_vals;
  logic                   unit_conflict;
  logic                   board_full;
  logic [3:0]             cur_idx;
  logic                   scan_conflict;

  // Slot s of unit u: rows 0-3, columns 4-7, 2x2 boxes 8-11 (box b at row 2*b[1], col 2*b[0]).
  function automatic logic [3:0] cell_index(input logic [3:0] u, input logic [1:0] s);
    logic [1:0] r;
    logic [1:0] c;
    r = 2'd0;
    c = 2'd0;
    if (u < 4'd4) begin
      r = u[1:0];
      c = s;
    end else if (u < 4'd8) begin
      r = s;
      c = u[1:0];
    end else begin
      r = {u[1], s[1]};
      c = {u[0], s[0]};
    end
    return {r, c};
  endfunction

  function automatic logic dup(input logic [CELL_BITS-1:0] a, input logic [CELL_BITS-1:0] b);
    return (a != '0) && (a == b);
  endfunction

  // Out-of-range clue nibbles are treated as empty, and clue-ness follows the stored value.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_cells
      assign load_grid[gi*CELL_BITS +: CELL_BITS] =
        (bus.puzzle_in[gi*CELL_BITS +: CELL_BITS] <= CELL_BITS'(4))
          ? bus.puzzle_in[gi*CELL_BITS +: CELL_BITS] : '0;
      assign load_fixed[gi]   = |load_grid[gi*CELL_BITS +: CELL_BITS];
      assign cell_nonzero[gi] = |grid_reg[gi*CELL_BITS +: CELL_BITS];
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_unit
      assign unit_vals[gi*CELL_BITS +: CELL_BITS] =
        grid_reg[cell_index(unit_reg, 2'(gi))*CELL_BITS +: CELL_BITS];
    end
  endgenerate

  assign unit_conflict =
      dup(unit_vals[0*CELL_BITS +: CELL_BITS], unit_vals[1*CELL_BITS +: CELL_BITS])
    | dup(unit_vals[0*CELL_BITS +: CELL_BITS], unit_vals[2*CELL_BITS +: CELL_BITS])
    | dup(unit_vals[0*CELL_BITS +: CELL_BITS], unit_vals[3*CELL_BITS +: CELL_BITS])
    | dup(unit_vals[1*CELL_BITS +: CELL_BITS], unit_vals[2*CELL_BITS +: CELL_BITS])
    | dup(unit_vals[1*CELL_BITS +: CELL_BITS], unit_vals[3*CELL_BITS +: CELL_BITS])
    | dup(unit_vals[2*CELL_BITS +: CELL_BITS], unit_vals[3*CELL_BITS +: CELL_BITS]);

  assign board_full    = &cell_nonzero;
  assign scan_conflict = conflict_acc_reg | unit_conflict;
  assign cur_idx       = {row_reg, col_reg};

  always_comb begin
    state_next        = state_reg;
    grid_next         = grid_reg;
    fixed_next        = fixed_reg;
    row_next          = row_reg;
    col_next          = col_reg;
    error_next        = error_reg;
    win_next          = win_reg;
    busy_next         = busy_reg;
    unit_next         = unit_reg;
    conflict_acc_next = conflict_acc_reg;

    if (bus.load) begin
      grid_next         = load_grid;
      fixed_next        = load_fixed;
      row_next          = 2'd0;
      col_next          = 2'd0;
      error_next        = 1'b0;
      win_next          = 1'b0;
      busy_next         = 1'b0;
      unit_next         = 4'd0;
      conflict_acc_next = 1'b0;
      state_next        = ST_PLAY;
    end else begin
      case (state_reg)
        ST_PLAY: begin
          // A rejected digit still wins arbitration, so no button acts that cycle.
          if (bus.digit_valid) begin
            if (!fixed_reg[cur_idx] && (bus.digit_in <= 3'd4)) begin
              grid_next[cur_idx*CELL_BITS +: CELL_BITS] = CELL_BITS'(bus.digit_in);
              busy_next         = 1'b1;
              unit_next         = 4'd0;
              conflict_acc_next = 1'b0;
              state_next        = ST_CHECK;
            end
          end else if (bus.btn_up) begin
            row_next = row_reg - 2'd1;
          end else if (bus.btn_down) begin
            row_next = row_reg + 2'd1;
          end else if (bus.btn_left) begin
            col_next = col_reg - 2'd1;
          end else if (bus.btn_right) begin
            col_next = col_reg + 2'd1;
          end
        end
        ST_CHECK: begin
          conflict_acc_next = scan_conflict;
          unit_next         = unit_reg + 4'd1;
          if (unit_reg == 4'(N_UNITS - 1)) begin
            error_next = scan_conflict;
            win_next   = !scan_conflict && board_full;
            busy_next  = 1'b0;
            unit_next  = 4'd0;
            state_next = (!scan_conflict && board_full) ? ST_WIN : ST_PLAY;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= ST_IDLE;
      grid_reg         <= '0;
      fixed_reg        <= '0;
      row_reg          <= 2'd0;
      col_reg          <= 2'd0;
      error_reg        <= 1'b0;
      win_reg          <= 1'b0;
      busy_reg         <= 1'b0;
      unit_reg         <= 4'd0;
      conflict_acc_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      grid_reg         <= grid_next;
      fixed_reg        <= fixed_next;
      row_reg          <= row_next;
      col_reg          <= col_next;
      error_reg        <= error_next;
      win_reg          <= win_next;
      busy_reg         <= busy_next;
      unit_reg         <= unit_next;
      conflict_acc_reg <= conflict_acc_next;
    end
  end

  assign bus.grid       = grid_reg;
  assign bus.fixed_mask = fixed_reg;
  assign bus.cursor_row = row_reg;
  assign bus.cursor_col = col_reg;
  assign bus.error_flag = error_reg;
  assign bus.win_flag   = win_reg;
  assign bus.busy       = busy_reg;
endmodule

// File: tb/tb_sudoku_game_ctrl.sv
// Directed and randomized stimulus for sudoku_game_ctrl, checked every cycle against a
// board-level model that judges conflicts by row/column/box membership of cell pairs.
module tb_sudoku_game_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sudoku_game_ctrl_if bus ();
  sudoku_game_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  localparam logic [63:0] PUZ = 64'h1234_3412_2143_4320;
  int sol [16] = '{1,2,3,4, 3,4,1,2, 2,1,4,3, 4,3,2,1};

  int checks = 0;
  int fails  = 0;

  // Reference model: 0 idle, 1 play, 2 check, 3 win.
  int m_grid [16];
  bit m_fixed [16];
  int m_r, m_c, m_mode, m_left;
  bit m_err, m_win, m_busy;

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_grid[i] = 0;
      m_fixed[i] = 1'b0;
    end
    m_r = 0; m_c = 0; m_mode = 0; m_left = 0;
    m_err = 1'b0; m_win = 1'b0; m_busy = 1'b0;
  endfunction

  function automatic bit board_conflict();
    for (int i = 0; i < 16; i++)
      for (int j = i + 1; j < 16; j++) begin
        bit same_row, same_col, same_box;
        same_row = (i / 4) == (j / 4);
        same_col = (i % 4) == (j % 4);
        same_box = ((i / 8) == (j / 8)) && (((i % 4) / 2) == ((j % 4) / 2));
        if (m_grid[i] != 0 && m_grid[i] == m_grid[j] && (same_row || same_col || same_box))
          return 1'b1;
      end
    return 1'b0;
  endfunction

  function automatic bit board_full();
    for (int i = 0; i < 16; i++)
      if (m_grid[i] == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [63:0] model_grid();
    logic [63:0] g;
    for (int i = 0; i < 16; i++) g[4*i +: 4] = 4'(m_grid[i]);
    return g;
  endfunction

  function automatic logic [15:0] model_fixed();
    logic [15:0] f;
    for (int i = 0; i < 16; i++) f[i] = m_fixed[i];
    return f;
  endfunction

  function automatic void model_edge();
    if (rst) begin
      model_reset();
    end else if (bus.load) begin
      for (int i = 0; i < 16; i++) begin
        int v;
        v = int'(bus.puzzle_in[4*i +: 4]);
        if (v > 4) v = 0;
        m_grid[i] = v;
        m_fixed[i] = (v != 0);
      end
      m_r = 0; m_c = 0; m_mode = 1; m_left = 0;
      m_err = 1'b0; m_win = 1'b0; m_busy = 1'b0;
    end else if (m_mode == 1) begin
      if (bus.digit_valid) begin
        if (!m_fixed[m_r*4 + m_c] && int'(bus.digit_in) <= 4) begin
          m_grid[m_r*4 + m_c] = int'(bus.digit_in);
          m_mode = 2; m_left = 12; m_busy = 1'b1;
        end
      end else if (bus.btn_up)    m_r = (m_r + 3) % 4;
      else if (bus.btn_down)      m_r = (m_r + 1) % 4;
      else if (bus.btn_left)      m_c = (m_c + 3) % 4;
      else if (bus.btn_right)     m_c = (m_c + 1) % 4;
    end else if (m_mode == 2) begin
      m_left--;
      if (m_left == 0) begin
        m_err  = board_conflict();
        m_win  = !m_err && board_full();
        m_busy = 1'b0;
        m_mode = m_win ? 3 : 1;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".grid"},  bus.grid, model_grid());
    chk({tag, ".fixed"}, 64'(bus.fixed_mask), 64'(model_fixed()));
    chk({tag, ".row"},   64'(bus.cursor_row), 64'(m_r));
    chk({tag, ".col"},   64'(bus.cursor_col), 64'(m_c));
    chk({tag, ".err"},   64'(bus.error_flag), 64'(m_err));
    chk({tag, ".win"},   64'(bus.win_flag), 64'(m_win));
    chk({tag, ".busy"},  64'(bus.busy), 64'(m_busy));
  endtask

  task automatic clear_inputs();
    bus.load = 1'b0; bus.btn_up = 1'b0; bus.btn_down = 1'b0;
    bus.btn_left = 1'b0; bus.btn_right = 1'b0; bus.digit_valid = 1'b0; bus.digit_in = 3'd0;
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
    $display("step %-10s row=%0d col=%0d busy=%0b err=%0b win=%0b grid=%h",
             tag, bus.cursor_row, bus.cursor_col, bus.busy, bus.error_flag, bus.win_flag, bus.grid);
    clear_inputs();
  endtask

  task automatic digit(input int d, input string tag);
    bus.digit_valid = 1'b1;
    bus.digit_in = 3'(d);
    step(tag);
  endtask

  initial begin
    clear_inputs();
    bus.puzzle_in = '0;
    model_reset();

    rst = 1'b1;
    step("rst0");
    step("rst1");
    rst = 1'b0;
    chk("reset_grid", bus.grid, 64'd0);
    chk("reset_busy", 64'(bus.busy), 64'd0);

    bus.load = 1'b1; bus.puzzle_in = PUZ; step("load");
    chk("load_grid", bus.grid, PUZ);
    chk("load_fixed", 64'(bus.fixed_mask), 64'hFFFE);

    bus.btn_up = 1'b1; step("up_wrap");
    chk("up_wrap_row", 64'(bus.cursor_row), 64'd3);
    bus.btn_left = 1'b1; step("left_wrap");
    chk("left_wrap_col", 64'(bus.cursor_col), 64'd3);
    bus.btn_up = 1'b1; bus.btn_down = 1'b1; step("up_down");
    chk("prio_row", 64'(bus.cursor_row), 64'd2);

    bus.btn_down = 1'b1; step("down");
    bus.btn_down = 1'b1; step("down");
    bus.btn_right = 1'b1; step("right");
    bus.btn_right = 1'b1; step("right");
    digit(3, "fixed_wr");
    chk("fixed_grid", bus.grid, PUZ);
    chk("fixed_busy", 64'(bus.busy), 64'd0);

    bus.btn_left = 1'b1; step("left");
    digit(2, "err_wr");
    chk("err_cell", 64'(bus.grid[3:0]), 64'd2);
    for (int i = 0; i < 11; i++) begin
      bus.btn_right = 1'b1;  // dropped while busy
      step("err_scan");
      chk("err_busy", 64'(bus.busy), 64'd1);
    end
    step("err_done");
    chk("err_flag", 64'(bus.error_flag), 64'd1);
    chk("err_win", 64'(bus.win_flag), 64'd0);

    digit(1, "win_wr");
    for (int i = 0; i < 12; i++) step("win_scan");
    chk("win_flag", 64'(bus.win_flag), 64'd1);
    chk("win_err", 64'(bus.error_flag), 64'd0);
    bus.btn_right = 1'b1; step("win_btn");
    chk("win_frozen_col", 64'(bus.cursor_col), 64'd0);
    digit(0, "win_dig");
    chk("win_frozen_cell", 64'(bus.grid[3:0]), 64'd1);

    bus.load = 1'b1; bus.puzzle_in = PUZ; step("reload");
    digit(2, "ab_err");
    for (int i = 0; i < 12; i++) step("ab_scan1");
    chk("ab_err_set", 64'(bus.error_flag), 64'd1);
    digit(1, "ab_wr");
    for (int i = 0; i < 4; i++) step("ab_scan2");
    bus.load = 1'b1; bus.puzzle_in = PUZ; step("ab_load");
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_err", 64'(bus.error_flag), 64'd0);
    chk("abort_grid", bus.grid, PUZ);

    digit(1, "rst_wr");
    for (int i = 0; i < 3; i++) step("rst_scan");
    rst = 1'b1; step("rst_mid");
    rst = 1'b0;
    chk("rst_mid_grid", bus.grid, 64'd0);
    digit(1, "idle_dig");
    bus.btn_down = 1'b1; step("idle_btn");
    chk("idle_row", 64'(bus.cursor_row), 64'd0);

    for (int n = 0; n < 3000; n++) begin
      int x;
      x = $urandom_range(0, 999);
      if (x < 3) rst = 1'b1;
      if (x < 25) begin
        logic [63:0] p;
        for (int i = 0; i < 16; i++) begin
          int v, y;
          v = sol[i];
          y = $urandom_range(0, 9);
          if (y < 3) v = 0;
          else if (y == 3) v = $urandom_range(0, 15);
          p[4*i +: 4] = 4'(v);
        end
        bus.load = 1'b1;
        bus.puzzle_in = p;
      end
      bus.btn_up    = ($urandom_range(0, 9) < 2);
      bus.btn_down  = ($urandom_range(0, 9) < 2);
      bus.btn_left  = ($urandom_range(0, 9) < 2);
      bus.btn_right = ($urandom_range(0, 9) < 2);
      bus.digit_valid = ($urandom_range(0, 9) < 3);
      bus.digit_in = ($urandom_range(0, 1) == 1) ? 3'(sol[m_r*4 + m_c]) : 3'($urandom_range(0, 7));
      step("rand");
      rst = 1'b0;
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
